rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Parametrised power-up and reset sequencer for the DAC clocking domain, one level above the DAC clock generator.
- Qualifies the DAC PLL lock, holds the system reset for a programmable time, then issues one DAC_SET pulse per DAC channel on a staggered timeline.
- Generalises the fixed single-pulse reset counter to CH_NUM channels with:
  - lock glitch filtering,
  - lock-loss recovery,
  - a software re-sequence request,
  - status outputs.

Parameters:
- CH_NUM, 2: number of DAC channels, range 1..8.
- CNT_W, 32: width of the sequence counter.
- LOCK_FILT, 16: consecutive synchronised lock-high cycles required before the lock is qualified (>=1).
- RST_CYC, 2000: cycles SYS_RST is held high after lock is qualified (>=1).
- SET_START, 20000: counter value at which DAC_SET[0] asserts (must be >= RST_CYC).
- SET_LEN, 1000: DAC_SET pulse width in cycles (>=1).
- SET_GAP, 0: idle cycles between consecutive channel pulses.

Ports:
- SYS_CLK, in, 1: sequencer clock (DAC 120 MHz domain).
- SYS_RST_N, in, 1: asynchronous active-low reset.
- PLL_LOCKED, in, 1: raw PLL lock, asynchronous to SYS_CLK.
- RESYNC_REQ, in, 1: single-cycle request to rerun the sequence from reset hold.
- SYS_RST, out, 1: active-high downstream reset.
- DAC_SET, out, CH_NUM: per-channel setup pulses.
- SEQ_DONE, out, 1: sequence complete, steady.
- LOCK_LOST_CNT, out, 8: saturating count of qualified-lock losses.
- SEQ_STATE, out, 3: current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, SYS_CLK. Reset SYS_RST_N is asynchronous, active-low.
- Reset values (SYS_RST_N low):
  - all flops cleared;
  - SYS_RST=1, DAC_SET=0, SEQ_DONE=0, LOCK_LOST_CNT=0;
  - state=IDLE (SEQ_STATE=0).
- Output registration: all outputs are registered and change on the same edge as the state/counter update that implies them.
- Lock qualification:
  - PLL_LOCKED passes through a 2-flop synchroniser, then a filter counter.
  - lock_ok sets after LOCK_FILT consecutive synchronised highs.
  - lock_ok clears on the first synchronised low.
  - lock_ok therefore rises LOCK_FILT+2 cycles after PLL_LOCKED rises.
- State machine:
  - IDLE(0): SYS_RST=1. On lock_ok, go to HOLD and set cnt=0.
  - HOLD(1): SYS_RST=1. cnt increments each cycle. When cnt==RST_CYC-1, go to WAIT on the next edge; SYS_RST=0 from cnt==RST_CYC.
  - WAIT(2): cnt increments. When cnt==SET_START-1, go to PULSE.
  - PULSE(3):
    - DAC_SET[i]=1 exactly for cnt in [SET_START+i*(SET_LEN+SET_GAP), SET_START+i*(SET_LEN+SET_GAP)+SET_LEN).
    - At most one bit is high at a time. Pulses are one-hot, ascending channel order, and never overlap, even with SET_GAP=0 (back-to-back).
    - Go to DONE when cnt reaches T_END = SET_START + CH_NUM*(SET_LEN+SET_GAP) - SET_GAP.
  - DONE(4): SEQ_DONE=1, DAC_SET=0, SYS_RST=0. cnt holds.
- Counter width: cnt saturates at 2^CNT_W-1 and never wraps. T_END must be < 2^CNT_W; the implementation checks this at elaboration.
- Lock loss: lock_ok falling in any state other than IDLE causes, on the next edge:
  - state=IDLE, SYS_RST=1, DAC_SET=0, SEQ_DONE=0, cnt=0;
  - LOCK_LOST_CNT increments, saturating at 255.
  - A pulse in progress is truncated.
  - Loss while already in IDLE does not count.
- RESYNC_REQ:
  - Sampled in HOLD, WAIT, PULSE or DONE: go to HOLD with cnt=0, SYS_RST=1, DAC_SET=0, SEQ_DONE=0.
  - Ignored in IDLE.
- Simultaneous events: lock loss and RESYNC_REQ in the same cycle resolve as lock loss (IDLE, counter increments).
- Mid-operation reset: SYS_RST_N low restores all reset values immediately (asynchronous), including LOCK_LOST_CNT.

Test Plan:
Bench parameters: CH_NUM=2, LOCK_FILT=4, RST_CYC=4, SET_START=10, SET_LEN=3, SET_GAP=2.
1. Release SYS_RST_N with PLL_LOCKED=1 held -> HOLD entered 6 cycles later; SYS_RST high through cnt 0..3 and low from cnt=4; DAC_SET=2'b01 for cnt 10..12 and 2'b10 for cnt 15..17; SEQ_DONE=1 from cnt=18 and stays.
2. PLL_LOCKED glitches high for 3 cycles, then low -> state stays IDLE; SYS_RST=1; LOCK_LOST_CNT=0.
3. Drop PLL_LOCKED at cnt=11 (mid DAC_SET[0]) -> 3 cycles later DAC_SET=0, SYS_RST=1, SEQ_STATE=0, LOCK_LOST_CNT=1; relock reruns the full timeline of scenario 1.
4. RESYNC_REQ pulse in DONE -> next cycle SEQ_DONE=0, SYS_RST=1, cnt=0; timeline repeats identically.
5. RESYNC_REQ in the same cycle lock_ok falls -> IDLE taken, LOCK_LOST_CNT increments; 300 forced losses -> LOCK_LOST_CNT saturates at 255.
6. SET_GAP=0, CH_NUM=4 -> DAC_SET walks 0001,0010,0100,1000, 3 cycles each, no overlap and no idle cycle between pulses; SEQ_DONE at cnt=22.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Power-up/reset sequencer for the DAC clock domain: qualifies PLL lock, holds SYS_RST,
// then issues one staggered DAC_SET pulse per channel. Recovers from lock loss and resync.
module rst_seq_ctrl #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned RST_CYC   = 2000,
  parameter int unsigned SET_START = 20000,
  parameter int unsigned SET_LEN   = 1000,
  parameter int unsigned SET_GAP   = 0
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST_N,
  input  logic              PLL_LOCKED,
  input  logic              RESYNC_REQ,
  output logic              SYS_RST,
  output logic [CH_NUM-1:0] DAC_SET,
  output logic              SEQ_DONE,
  output logic [7:0]        LOCK_LOST_CNT,
  output logic [2:0]        SEQ_STATE
);

  localparam int unsigned FiltW = $clog2(LOCK_FILT + 1);
  localparam longint unsigned Step = longint'(SET_LEN) + longint'(SET_GAP);
  localparam longint unsigned TEnd =
      longint'(SET_START) + longint'(CH_NUM) * Step - longint'(SET_GAP);

  localparam logic [CNT_W-1:0] CntRstLast = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CntSetLast = CNT_W'(SET_START - 1);
  localparam logic [CNT_W-1:0] CntTEnd    = CNT_W'(TEnd);
  localparam logic [FiltW-1:0] FiltLast   = FiltW'(LOCK_FILT - 1);

  if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch
    $error("rst_seq_ctrl: CH_NUM must be in 1..8");
  end
  if (LOCK_FILT < 1 || RST_CYC < 1 || SET_LEN < 1 || SET_START < RST_CYC) begin : g_bad_timing
    $error("rst_seq_ctrl: invalid LOCK_FILT/RST_CYC/SET_LEN/SET_START");
  end
  if (CNT_W < 64) begin : g_w_chk
    if (TEnd >= (64'd1 << CNT_W)) begin : g_bad_tend
      $error("rst_seq_ctrl: sequence end does not fit in CNT_W");
    end
  end

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHold  = 3'd1,
    StWait  = 3'd2,
    StPulse = 3'd3,
    StDone  = 3'd4
  } state_e;

  logic [1:0]        sync_q;
  logic [FiltW-1:0]  filt_q, filt_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              sys_rst_q, sys_rst_d;
  logic [CH_NUM-1:0] dac_set_q, dac_set_d;
  logic              seq_done_q, seq_done_d;
  logic [7:0]        lost_q, lost_d;
  logic              lock_sync, lock_ok;
  logic [63:0]       cnt64, win_lo;

  // lock_ok is the qualified lock seen at this edge: the current synchronised sample plus
  // LOCK_FILT-1 earlier consecutive highs recorded by the saturating filter.
  assign lock_sync = sync_q[1];
  assign lock_ok   = lock_sync && (filt_q == FiltLast);

  always_comb begin
    filt_d = filt_q;
    if (!lock_sync) begin
      filt_d = '0;
    end else if (!lock_ok) begin
      filt_d = filt_q + FiltW'(1);
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    // Lock loss outranks a simultaneous resync request.
    if (state_q != StIdle && !lock_ok) begin
      state_d = StIdle;
      cnt_d   = '0;
      if (lost_q != 8'hff) lost_d = lost_q + 8'd1;
    end else if (state_q != StIdle && RESYNC_REQ) begin
      state_d = StHold;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lock_ok) begin
            state_d = StHold;
            cnt_d   = '0;
          end
        end
        StHold: begin
          cnt_d = cnt_inc;
          if (cnt_q == CntRstLast) state_d = (RST_CYC == SET_START) ? StPulse : StWait;
        end
        StWait: begin
          cnt_d = cnt_inc;
          if (cnt_q == CntSetLast) state_d = StPulse;
        end
        StPulse: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntTEnd) state_d = StDone;
        end
        StDone: ;
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next state/count so they register on the same edge.
  always_comb begin
    sys_rst_d  = (state_d == StIdle) || (state_d == StHold);
    seq_done_d = (state_d == StDone);
    dac_set_d  = '0;
    cnt64      = 64'(cnt_d);
    win_lo     = '0;
    if (state_d == StPulse) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        win_lo = 64'(SET_START) + 64'(i) * Step;
        if (cnt64 >= win_lo && cnt64 < win_lo + 64'(SET_LEN)) dac_set_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      sync_q     <= '0;
      filt_q     <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      sys_rst_q  <= 1'b1;
      dac_set_q  <= '0;
      seq_done_q <= 1'b0;
      lost_q     <= '0;
    end else begin
      sync_q     <= {sync_q[0], PLL_LOCKED};
      filt_q     <= filt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sys_rst_q  <= sys_rst_d;
      dac_set_q  <= dac_set_d;
      seq_done_q <= seq_done_d;
      lost_q     <= lost_d;
    end
  end

  assign SYS_RST       = sys_rst_q;
  assign DAC_SET       = dac_set_q;
  assign SEQ_DONE      = seq_done_q;
  assign LOCK_LOST_CNT = lost_q;
  assign SEQ_STATE     = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: two configurations driven in lockstep and compared every cycle
// against a timeline model computed from the sequence rules.
module tb_rst_seq_ctrl;

  localparam int LF = 4;
  localparam int RC = 4;
  localparam int SS = 10;
  localparam int SL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll = 1'b0;
  logic resync = 1'b0;

  logic       rst0, done0, rst1, done1;
  logic [1:0] dac0;
  logic [3:0] dac1;
  logic [7:0] lost0, lost1;
  logic [2:0] st0, st1;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .CH_NUM(2), .CNT_W(32), .LOCK_FILT(LF), .RST_CYC(RC), .SET_START(SS), .SET_LEN(SL),
    .SET_GAP(2)
  ) u0 (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .PLL_LOCKED(pll), .RESYNC_REQ(resync),
    .SYS_RST(rst0), .DAC_SET(dac0), .SEQ_DONE(done0), .LOCK_LOST_CNT(lost0), .SEQ_STATE(st0)
  );

  rst_seq_ctrl #(
    .CH_NUM(4), .CNT_W(32), .LOCK_FILT(LF), .RST_CYC(RC), .SET_START(SS), .SET_LEN(SL),
    .SET_GAP(0)
  ) u1 (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .PLL_LOCKED(pll), .RESYNC_REQ(resync),
    .SYS_RST(rst1), .DAC_SET(dac1), .SEQ_DONE(done1), .LOCK_LOST_CNT(lost1), .SEQ_STATE(st1)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: window of raw lock samples plus per-instance timeline position.
  bit hist[$];
  bit run[2];
  int t[2];
  int lost[2];
  int chn[2] = '{2, 4};
  int gap[2] = '{2, 0};

  function automatic int tend(int k);
    return SS + chn[k] * (SL + gap[k]) - gap[k];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < LF + 2; j++) hist.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      run[k] = 1'b0;
      t[k] = 0;
      lost[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit lock;
    hist.push_front(pll);
    void'(hist.pop_back());
    // Qualified when the samples from 2..LF+1 edges ago were all high.
    lock = 1'b1;
    for (int j = 2; j < LF + 2; j++) lock &= hist[j];
    for (int k = 0; k < 2; k++) begin
      if (run[k] && !lock) begin
        run[k] = 1'b0;
        t[k] = 0;
        if (lost[k] < 255) lost[k]++;
      end else if (run[k] && resync) begin
        t[k] = 0;
      end else if (run[k]) begin
        if (t[k] < tend(k)) t[k]++;
      end else if (lock) begin
        run[k] = 1'b1;
        t[k] = 0;
      end
    end
  endtask

  task automatic check_all(string tag);
    logic       e_rst, e_done;
    logic [7:0] e_dac;
    logic [2:0] e_st;
    int         lo;
    for (int k = 0; k < 2; k++) begin
      e_dac = '0;
      if (!run[k]) begin
        e_rst = 1'b1; e_done = 1'b0; e_st = 3'd0;
      end else begin
        e_rst  = (t[k] < RC);
        e_done = (t[k] >= tend(k));
        e_st   = (t[k] < RC) ? 3'd1 : (t[k] < SS) ? 3'd2 : (t[k] < tend(k)) ? 3'd3 : 3'd4;
        for (int i = 0; i < chn[k]; i++) begin
          lo = SS + i * (SL + gap[k]);
          if (!e_done && t[k] >= lo && t[k] < lo + SL) e_dac[i] = 1'b1;
        end
      end
      if (k == 0) begin
        chk({tag, " u0 SYS_RST"}, 32'(rst0), 32'(e_rst));
        chk({tag, " u0 DAC_SET"}, 32'(dac0), 32'(e_dac));
        chk({tag, " u0 SEQ_DONE"}, 32'(done0), 32'(e_done));
        chk({tag, " u0 SEQ_STATE"}, 32'(st0), 32'(e_st));
        chk({tag, " u0 LOCK_LOST_CNT"}, 32'(lost0), 32'(lost[0]));
      end else begin
        chk({tag, " u1 SYS_RST"}, 32'(rst1), 32'(e_rst));
        chk({tag, " u1 DAC_SET"}, 32'(dac1), 32'(e_dac));
        chk({tag, " u1 SEQ_DONE"}, 32'(done1), 32'(e_done));
        chk({tag, " u1 SEQ_STATE"}, 32'(st1), 32'(e_st));
        chk({tag, " u1 LOCK_LOST_CNT"}, 32'(lost1), 32'(lost[1]));
      end
    end
  endtask

  task automatic step(bit p, bit r, string tag);
    pll = p;
    resync = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    resync = 1'b0;
  endtask

  task automatic do_reset(bit p);
    #2;
    rst_n = 1'b0;
    pll = p;
    resync = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Lock glitch shorter than the filter never leaves IDLE.
    do_reset(1'b0);
    repeat (3) step(1'b0, 1'b0, "s2 low");
    repeat (3) step(1'b1, 1'b0, "s2 glitch");
    repeat (8) step(1'b0, 1'b0, "s2 after");
    chk("s2 idle", 32'(st0), 32'd0);
    chk("s2 no loss", 32'(lost0), 32'd0);

    // Lock held through reset release: HOLD on the 6th edge, full timeline.
    do_reset(1'b1);
    repeat (5) step(1'b1, 1'b0, "s1 qual");
    chk("s1 still idle", 32'(st0), 32'd0);
    step(1'b1, 1'b0, "s1 hold entry");
    chk("s1 hold", 32'(st0), 32'd1);
    repeat (25) step(1'b1, 1'b0, "s1 run");
    chk("s1 u0 done", 32'(done0), 32'd1);
    chk("s1 u1 done", 32'(done1), 32'd1);

    // Lock loss mid-pulse, then relock reruns the timeline.
    do_reset(1'b1);
    for (int n = 0; n < 40 && !(run[0] && t[0] == 11); n++) step(1'b1, 1'b0, "s3 reach");
    chk("s3 mid pulse", 32'(dac0), 32'd1);
    repeat (3) step(1'b0, 1'b0, "s3 drop");
    chk("s3 idle", 32'(st0), 32'd0);
    chk("s3 lost", 32'(lost0), 32'd1);
    repeat (30) step(1'b1, 1'b0, "s3 relock");

    // Resync from DONE replays the timeline.
    step(1'b1, 1'b1, "s4 resync");
    chk("s4 hold", 32'(st0), 32'd1);
    repeat (30) step(1'b1, 1'b0, "s4 rerun");

    // Resync coinciding with the lock falling resolves as a loss.
    repeat (2) step(1'b0, 1'b0, "s5 drop");
    step(1'b0, 1'b1, "s5 clash");
    chk("s5 idle", 32'(st0), 32'd0);
    chk("s5 lost", 32'(lost0), 32'd2);
    for (int n = 0; n < 300; n++) begin
      for (int m = 0; m < 20 && !run[0]; m++) step(1'b1, 1'b0, "s5 relock");
      repeat (3) step(1'b0, 1'b0, "s5 loss");
    end
    chk("s5 sat u0", 32'(lost0), 32'd255);
    chk("s5 sat u1", 32'(lost1), 32'd255);

    // Asynchronous reset clears the saturated loss counter.
    do_reset(1'b1);
    chk("rst lost cleared", 32'(lost0), 32'd0);

    // Random lock wander and resync requests.
    begin
      bit p = 1'b1;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 11) == 0) p = ~p;
        step(p, ($urandom_range(0, 15) == 0), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
